// File: rtl/swervolf_wb_pkg.sv
// Shared constants for the SweRVolf Wishbone single-transfer initiator:
// FSM state encoding, the data returned on write/timeout responses, default timeout.
package swervolf_wb_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUS  = 2'd1;
    localparam logic [1:0] ST_RSP  = 2'd2;

    localparam logic [31:0] RSP_DAT_NONE = 32'h0;

    localparam int TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/swervolf_wb_master.sv
// Wishbone classic single-transfer initiator: one valid/ready command becomes one
// bus cycle, and its result (read data or timeout error) is held on the response port.
module swervolf_wb_master
    import swervolf_wb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic          i_clk,
    input  logic          i_rst,

    // Both ports handshake on a rising clock edge where valid and ready are both
    // high; the sender keeps valid and its payload stable until that edge.
    input  logic          i_cmd_valid,
    output logic          o_cmd_ready,
    input  logic          i_cmd_we,
    input  logic [AW-1:0] i_cmd_adr,
    input  logic [31:0]   i_cmd_dat,
    input  logic [3:0]    i_cmd_sel,

    output logic          o_rsp_valid,
    input  logic          i_rsp_ready,
    output logic [31:0]   o_rsp_dat,
    output logic          o_rsp_err,

    output logic [AW-1:0] o_wb_adr,
    output logic [31:0]   o_wb_dat,
    output logic [3:0]    o_wb_sel,
    output logic          o_wb_we,
    output logic          o_wb_cyc,
    output logic          o_wb_stb,
    input  logic [31:0]   i_wb_rdt,
    input  logic          i_wb_ack,

    output logic [1:0]    o_dbg_state
);

    localparam bit TO_EN = (TIMEOUT != 0);
    localparam int CW    = (TIMEOUT > 0) ? (($clog2(TIMEOUT + 1) > 0) ? $clog2(TIMEOUT + 1) : 1) : 1;
    localparam int CNT_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CW-1:0] CNT_LAST = CNT_LAST_I[CW-1:0];

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          cmd_ready_q, cmd_ready_d;
    logic          cyc_q, cyc_d;
    logic          we_q, we_d;
    logic [AW-1:0] adr_q, adr_d;
    logic [31:0]   dat_q, dat_d;
    logic [3:0]    sel_q, sel_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [31:0]   rsp_dat_q, rsp_dat_d;
    logic          rsp_err_q, rsp_err_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        sel_d       = sel_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            ST_IDLE: begin
                if (i_cmd_valid && cmd_ready_q) begin
                    we_d    = i_cmd_we;
                    adr_d   = i_cmd_adr;
                    dat_d   = i_cmd_dat;
                    sel_d   = i_cmd_sel;
                    cyc_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_BUS;
                end
            end
            ST_BUS: begin
                // Ack is checked first so an ack landing on the expiry cycle still completes.
                if (i_wb_ack) begin
                    cyc_d       = 1'b0;
                    rsp_dat_d   = we_q ? RSP_DAT_NONE : i_wb_rdt;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RSP;
                end else if (TO_EN && (cnt_q == CNT_LAST)) begin
                    cyc_d       = 1'b0;
                    rsp_dat_d   = RSP_DAT_NONE;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RSP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RSP: begin
                if (i_rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cyc_d   = 1'b0;
            end
        endcase

        cmd_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            cmd_ready_q <= 1'b0;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            sel_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_ready_q <= cmd_ready_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            sel_q       <= sel_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign o_cmd_ready = cmd_ready_q;
    assign o_wb_cyc    = cyc_q;
    assign o_wb_stb    = cyc_q;
    assign o_wb_we     = we_q;
    assign o_wb_adr    = adr_q;
    assign o_wb_dat    = dat_q;
    assign o_wb_sel    = sel_q;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_dat   = rsp_dat_q;
    assign o_rsp_err   = rsp_err_q;
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_swervolf_wb_master.sv
// Bench for swervolf_wb_master: syscon-style registered-ack responder, a transfer-level
// reference model checked every cycle, and directed transfers with literal expectations.
module tb_swervolf_wb_master;

    localparam int TO = 4;
    localparam int WAIT_MAX = 200;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_cmd_valid = 1'b0;
    logic        i_cmd_we = 1'b0;
    logic [31:0] i_cmd_adr = '0;
    logic [31:0] i_cmd_dat = '0;
    logic [3:0]  i_cmd_sel = '0;
    logic        i_rsp_ready = 1'b0;
    logic        o_cmd_ready, o_rsp_valid, o_rsp_err;
    logic [31:0] o_rsp_dat, o_wb_adr, o_wb_dat;
    logic [3:0]  o_wb_sel;
    logic        o_wb_we, o_wb_cyc, o_wb_stb;
    logic [31:0] i_wb_rdt;
    logic        i_wb_ack;
    logic [1:0]  o_dbg_state;

    int n_cmp = 0;
    int n_err = 0;
    int edge_cnt = 0;

    swervolf_wb_master #(.AW(32), .TIMEOUT(TO)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_we(i_cmd_we),
        .i_cmd_adr(i_cmd_adr), .i_cmd_dat(i_cmd_dat), .i_cmd_sel(i_cmd_sel),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_dat(o_rsp_dat),
        .o_rsp_err(o_rsp_err),
        .o_wb_adr(o_wb_adr), .o_wb_dat(o_wb_dat), .o_wb_sel(o_wb_sel), .o_wb_we(o_wb_we),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .i_wb_rdt(i_wb_rdt), .i_wb_ack(i_wb_ack),
        .o_dbg_state(o_dbg_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Responder: 16 words at 0x00-0x3f, registered ack after ack_delay extra cycles.
    logic [31:0] mem [16];
    logic [31:0] exp_mem [16];
    logic        ack_q = 1'b0;
    logic [31:0] rdt_q = '0;
    logic        spur_ack = 1'b0;
    int          ack_delay = 0;
    int          wcnt = 0;

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem[i] = '0;
            exp_mem[i] = '0;
        end
        mem[0] = 32'h0102_0304; exp_mem[0] = 32'h0102_0304;
        mem[1] = 32'hCAFE_F00D; exp_mem[1] = 32'hCAFE_F00D;
    end

    always @(posedge clk) begin
        ack_q <= 1'b0;
        if (o_wb_cyc && o_wb_stb && !ack_q && (o_wb_adr < 32'h40)) begin
            if (wcnt == ack_delay) begin
                ack_q <= 1'b1;
                wcnt  <= 0;
                rdt_q <= mem[o_wb_adr[5:2]];
                if (o_wb_we)
                    for (int b = 0; b < 4; b++)
                        if (o_wb_sel[b]) mem[o_wb_adr[5:2]][8*b +: 8] <= o_wb_dat[8*b +: 8];
            end else begin
                wcnt <= wcnt + 1;
            end
        end else begin
            wcnt <= 0;
        end
    end

    assign i_wb_ack = ack_q | spur_ack;
    assign i_wb_rdt = rdt_q;

    // Transfer-level model: a command is taken when the initiator is idle, the bus is
    // held for the command until an ack or TO cycles, then the response waits for ready.
    logic        m_armed = 1'b0;
    logic        m_cyc = 1'b0;
    logic        m_rsp_v = 1'b0;
    logic [31:0] m_rsp_dat = '0;
    logic        m_rsp_err = 1'b0;
    logic        m_we = 1'b0;
    logic [31:0] m_adr = '0;
    logic [31:0] m_dat = '0;
    logic [3:0]  m_sel = '0;
    int          m_cyc_n = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_armed = 1'b0; m_cyc = 1'b0; m_rsp_v = 1'b0; m_rsp_dat = '0; m_rsp_err = 1'b0;
            m_we = 1'b0; m_adr = '0; m_dat = '0; m_sel = '0; m_cyc_n = 0;
        end else begin
            if (m_rsp_v) begin
                if (i_rsp_ready) m_rsp_v = 1'b0;
            end else if (m_cyc) begin
                m_cyc_n++;
                if (i_wb_ack) begin
                    m_cyc = 1'b0;
                    m_rsp_v = 1'b1;
                    m_rsp_err = 1'b0;
                    m_rsp_dat = m_we ? 32'h0 : exp_mem[m_adr[5:2]];
                    if (m_we)
                        for (int b = 0; b < 4; b++)
                            if (m_sel[b]) exp_mem[m_adr[5:2]][8*b +: 8] = m_dat[8*b +: 8];
                end else if (m_cyc_n == TO) begin
                    m_cyc = 1'b0;
                    m_rsp_v = 1'b1;
                    m_rsp_err = 1'b1;
                    m_rsp_dat = 32'h0;
                end
            end else if (m_armed && i_cmd_valid) begin
                m_we = i_cmd_we; m_adr = i_cmd_adr; m_dat = i_cmd_dat; m_sel = i_cmd_sel;
                m_cyc = 1'b1;
                m_cyc_n = 0;
            end
            m_armed = 1'b1;
        end
    end

    always @(negedge clk) begin
        chk("cmd_ready", {31'b0, o_cmd_ready}, {31'b0, m_armed && !m_cyc && !m_rsp_v});
        chk("dbg_state", {30'b0, o_dbg_state}, m_cyc ? 32'd1 : (m_rsp_v ? 32'd2 : 32'd0));
        chk("wb_cyc", {31'b0, o_wb_cyc}, {31'b0, m_cyc});
        chk("wb_stb", {31'b0, o_wb_stb}, {31'b0, m_cyc});
        chk("rsp_valid", {31'b0, o_rsp_valid}, {31'b0, m_rsp_v});
        if (m_rsp_v || rst) begin
            chk("rsp_dat", o_rsp_dat, m_rsp_dat);
            chk("rsp_err", {31'b0, o_rsp_err}, {31'b0, m_rsp_err});
        end
        if (m_cyc || rst) begin
            chk("wb_adr", o_wb_adr, m_adr);
            chk("wb_dat", o_wb_dat, m_dat);
            chk("wb_sel", {28'b0, o_wb_sel}, {28'b0, m_sel});
            chk("wb_we", {31'b0, o_wb_we}, {31'b0, m_we});
        end
    end

    task automatic wait_ready();
        int t = 0;
        while (!o_cmd_ready && t < WAIT_MAX) begin
            @(negedge clk);
            t++;
        end
        if (t >= WAIT_MAX) chk("cmd_accept_bound", 32'd0, 32'd1);
    endtask

    task automatic do_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input int d, input int hold,
                          output logic [31:0] rdat, output logic err, output int lat);
        int acc;
        int t;
        @(negedge clk);
        ack_delay   = d;
        i_cmd_valid = 1'b1;
        i_cmd_we    = we;
        i_cmd_adr   = adr;
        i_cmd_dat   = dat;
        i_cmd_sel   = sel;
        wait_ready();
        @(posedge clk);
        #1;
        acc = edge_cnt;
        i_cmd_valid = 1'b0;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!o_rsp_valid && t < WAIT_MAX);
        if (t >= WAIT_MAX) chk("rsp_bound", 32'd0, 32'd1);
        lat  = edge_cnt - acc;
        rdat = o_rsp_dat;
        err  = o_rsp_err;
        if (hold > 0) begin
            i_cmd_valid = 1'b1;
            i_cmd_we    = 1'b1;
            i_cmd_adr   = 32'h3C;
            i_cmd_dat   = 32'hDEAD_BEEF;
            i_cmd_sel   = 4'hF;
            repeat (hold) @(negedge clk);
            i_cmd_valid = 1'b0;
        end
        i_rsp_ready = 1'b1;
        @(negedge clk);
        i_rsp_ready = 1'b0;
    endtask

    logic [31:0] rd;
    logic        er;
    int          lt;

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_cyc", {31'b0, o_wb_cyc}, 32'd0);
        chk("reset_ready", {31'b0, o_cmd_ready}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_release", {31'b0, o_cmd_ready}, 32'd1);

        do_cmd(1'b0, 32'h00, 32'h0, 4'hF, 0, 0, rd, er, lt);
        chk("rd0_dat", rd, 32'h0102_0304);
        chk("rd0_err", {31'b0, er}, 32'd0);
        chk("rd0_lat", lt, 32'd2);

        do_cmd(1'b1, 32'h10, 32'hA5A5_0F0F, 4'b0101, 0, 0, rd, er, lt);
        chk("wr10_dat", rd, 32'h0);
        chk("wr10_err", {31'b0, er}, 32'd0);
        chk("wr10_lat", lt, 32'd2);
        do_cmd(1'b0, 32'h10, 32'h0, 4'hF, 0, 0, rd, er, lt);
        chk("rd10_gpio", rd, 32'h00A5_000F);

        do_cmd(1'b0, 32'h100, 32'h0, 4'hF, 0, 0, rd, er, lt);
        chk("to_err", {31'b0, er}, 32'd1);
        chk("to_dat", rd, 32'h0);
        chk("to_lat", lt, TO);

        do_cmd(1'b0, 32'h00, 32'h0, 4'hF, TO - 2, 0, rd, er, lt);
        chk("ack_at_expiry_err", {31'b0, er}, 32'd0);
        chk("ack_at_expiry_dat", rd, 32'h0102_0304);
        chk("ack_at_expiry_lat", lt, TO);

        do_cmd(1'b0, 32'h04, 32'h0, 4'hF, TO - 1, 0, rd, er, lt);
        chk("late_ack_err", {31'b0, er}, 32'd1);
        chk("late_ack_dat", rd, 32'h0);

        do_cmd(1'b1, 32'h08, 32'h1122_3344, 4'hF, 0, 10, rd, er, lt);
        chk("bp_wr_err", {31'b0, er}, 32'd0);
        do_cmd(1'b0, 32'h08, 32'h0, 4'hF, 1, 0, rd, er, lt);
        chk("bp_rd_dat", rd, 32'h1122_3344);
        chk("bp_rd_lat", lt, 32'd3);

        @(negedge clk);
        spur_ack = 1'b1;
        i_rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        spur_ack = 1'b0;
        i_rsp_ready = 1'b0;

        @(negedge clk);
        i_cmd_valid = 1'b1;
        i_cmd_we    = 1'b0;
        i_cmd_adr   = 32'h100;
        wait_ready();
        @(posedge clk);
        #1 i_cmd_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_cyc", {31'b0, o_wb_cyc}, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_cyc", {31'b0, o_wb_cyc}, 32'd0);
        chk("async_rst_stb", {31'b0, o_wb_stb}, 32'd0);
        chk("async_rst_rsp", {31'b0, o_rsp_valid}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        do_cmd(1'b0, 32'h00, 32'h0, 4'hF, 0, 0, rd, er, lt);
        chk("post_rst_dat", rd, 32'h0102_0304);
        chk("post_rst_lat", lt, 32'd2);

        for (int i = 0; i < 4; i++) begin
            logic [31:0] wd;
            wd = $urandom_range(32'h7FFF_FFFF, 0);
            do_cmd(1'b1, 32'h20 + 32'(4 * i), wd, 4'hF, i % 3, i, rd, er, lt);
            chk("loop_wr_err", {31'b0, er}, 32'd0);
            do_cmd(1'b0, 32'h20 + 32'(4 * i), 32'h0, 4'hF, (i + 1) % 3, 0, rd, er, lt);
            chk("loop_rd_dat", rd, wd);
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

endmodule
